// File: rtl/aes_vector_checker.sv
// aes_vector_checker: vector-table BIST engine that drives an AES core and scores its results.
// Optional build macro AES_CHK_TIMEOUT_EN adds a per-vector watchdog in WAIT that flags timeout_err.
module aes_vector_checker #(
    parameter int N       = 128,
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [N-1:0]  cfg_key,
    input  logic [N-1:0]  cfg_pt,
    input  logic [N-1:0]  cfg_exp,
    input  logic [AW:0]   num_vec,
    input  logic          start,
    output logic          dut_enb,
    output logic [N-1:0]  dut_key,
    output logic [N-1:0]  dut_pt,
    input  logic [N-1:0]  dut_ct,
    input  logic          dut_valid,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   pass_cnt,
    output logic [AW:0]   fail_cnt,
    output logic [AW-1:0] first_fail_idx,
    output logic          first_fail_vld,
    output logic          timeout_err
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CHECK, DONE} state_t;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE     = (AW+1)'(1);
    state_t          state;
    logic [N-1:0]    key_mem [DEPTH];
    logic [N-1:0]    pt_mem  [DEPTH];
    logic [N-1:0]    exp_mem [DEPTH];
    logic [N-1:0]    result;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   idx_nxt;
    logic [AW:0]     n;
    logic [AW:0]     n_start;
    logic            cfg_ok;
    logic            bypass;
    logic            last;
    logic            timeout_hit;
    logic            vec_end;
    logic            vec_pass;
    assign cfg_ok   = {1'b0, cfg_addr} < DEPTH_W;
    // A write landing on the same cycle as start must be seen by the first issue (slot 0).
    assign bypass   = cfg_we && cfg_addr == '0;
    assign n_start  = num_vec > DEPTH_W ? DEPTH_W : num_vec;
    assign last     = {1'b0, idx} == n - ONE;
    assign idx_nxt  = idx + AW'(1);
    assign vec_end  = state == CHECK || timeout_hit;
    assign vec_pass = state == CHECK && result == exp_mem[idx];
    assign busy     = state == ISSUE || state == WAIT || state == CHECK;
`ifdef AES_CHK_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    assign timeout_hit = state == WAIT && !dut_valid && tcnt == TW'(TIMEOUT - 1);
    // Watchdog: counts WAIT cycles, zero elsewhere; the timeout flag is sticky until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt <= state == WAIT ? tcnt + TW'(1) : '0;
            if (timeout_hit)
                timeout_err <= 1'b1;
            else if (state == IDLE && start)
                timeout_err <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif
    // Vector table: writable only while idle, out-of-range slots dropped; not reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && cfg_we && cfg_ok) begin
            key_mem[cfg_addr] <= cfg_key;
            pt_mem[cfg_addr]  <= cfg_pt;
            exp_mem[cfg_addr] <= cfg_exp;
        end
    end
    // Run sequencer: issues each vector, captures the core result and scores it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            dut_enb        <= 1'b0;
            dut_key        <= '0;
            dut_pt         <= '0;
            result         <= '0;
            idx            <= '0;
            n              <= '0;
            done           <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            dut_enb <= 1'b0;
            if (vec_end) begin
                if (vec_pass)
                    pass_cnt <= pass_cnt + ONE;
                else begin
                    fail_cnt <= fail_cnt + ONE;
                    if (!first_fail_vld) begin
                        first_fail_vld <= 1'b1;
                        first_fail_idx <= idx;
                    end
                end
                if (last) begin
                    state <= DONE;
                    done  <= 1'b1;
                end else begin
                    idx     <= idx_nxt;
                    state   <= ISSUE;
                    dut_enb <= 1'b1;
                    dut_key <= key_mem[idx_nxt];
                    dut_pt  <= pt_mem[idx_nxt];
                end
            end else begin
                case (state)
                    IDLE: if (start) begin
                        n              <= n_start;
                        idx            <= '0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        first_fail_idx <= '0;
                        first_fail_vld <= 1'b0;
                        if (n_start == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ISSUE;
                            done    <= 1'b0;
                            dut_enb <= 1'b1;
                            dut_key <= bypass ? cfg_key : key_mem[0];
                            dut_pt  <= bypass ? cfg_pt : pt_mem[0];
                        end
                    end
                    ISSUE: state <= WAIT;
                    WAIT: if (dut_valid) begin
                        result <= dut_ct;
                        state  <= CHECK;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_aes_vector_checker.sv
// tb_aes_vector_checker: directed self-checking bench for aes_vector_checker with a latency-modelled core.
module tb_aes_vector_checker;
    localparam int N = 128, DEPTH = 16, AW = 4, TIMEOUT = 64, LAT = 10;
    localparam logic [N-1:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [N-1:0] FP = 128'h00112233445566778899aabbccddeeff;
    localparam logic [N-1:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [N-1:0]  cfg_key = '0, cfg_pt = '0, cfg_exp = '0;
    logic [AW:0]   num_vec = '0;
    logic          start = 1'b0;
    logic          dut_enb;
    logic [N-1:0]  dut_key, dut_pt;
    logic [N-1:0]  dut_ct;
    logic          dut_valid;
    logic          busy, done, first_fail_vld, timeout_err;
    logic [AW:0]   pass_cnt, fail_cnt;
    logic [AW-1:0] first_fail_idx;

    int checks = 0;
    int errors = 0;
    int enb_cnt = 0;
    int cyc_now = 0;
    int enb_cyc [0:127];
    logic core_silent = 1'b0;
    int core_cnt;

    aes_vector_checker #(.N(N), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_key(cfg_key), .cfg_pt(cfg_pt), .cfg_exp(cfg_exp), .num_vec(num_vec),
        .start(start), .dut_enb(dut_enb), .dut_key(dut_key), .dut_pt(dut_pt),
        .dut_ct(dut_ct), .dut_valid(dut_valid), .busy(busy), .done(done),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
        .first_fail_vld(first_fail_vld), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] core_f(input logic [N-1:0] k, input logic [N-1:0] p);
        return (k == FK && p == FP) ? FC : k ^ p;
    endfunction

    function automatic logic [N-1:0] skey(input int s);
        return {4{32'hA5A50000 + 32'(s)}};
    endfunction

    function automatic logic [N-1:0] spt(input int s);
        return {4{32'h0F0F0000 + 32'(s * 3)}};
    endfunction

    // Core model: result valid for one cycle, LAT cycles of WAIT after each issue.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt  <= 0;
            dut_valid <= 1'b0;
            dut_ct    <= '0;
        end else begin
            dut_valid <= 1'b0;
            if (dut_enb) begin
                core_cnt <= LAT - 1;
                dut_ct   <= core_f(dut_key, dut_pt);
            end else if (core_cnt != 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1 && !core_silent) dut_valid <= 1'b1;
            end
        end
    end

    // Issue-strobe monitor sampled on the falling edge.
    always @(negedge clk) begin
        cyc_now++;
        if (dut_enb) begin
            if (enb_cnt < 128) enb_cyc[enb_cnt] = cyc_now;
            enb_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [N-1:0] k, input logic [N-1:0] p, input logic [N-1:0] e);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = AW'(a); cfg_key = k; cfg_pt = p; cfg_exp = e;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic go(input int nv);
        @(negedge clk);
        num_vec = (AW+1)'(nv); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int c);
        c = 0;
        while (!done && c < bound) begin
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, b, k;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_enb", dut_enb, 0);
        chk("rst_key", dut_key, 0);
        chk("rst_pt", dut_pt, 0);
        chk("rst_pass", pass_cnt, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_ffv", first_fail_vld, 0);
        chk("rst_tmo", timeout_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        wr(0, FK, FP, FC);
        b = enb_cnt;
        go(1);
        chk("fips_key", dut_key, FK);
        wait_done(100, c);
        chk("fips_cycles", c, 12);
        chk("fips_done", done, 1);
        chk("fips_pass", pass_cnt, 1);
        chk("fips_fail", fail_cnt, 0);
        chk("fips_ffv", first_fail_vld, 0);
        chk("fips_issues", enb_cnt - b, 1);
        chk("fips_pt_held", dut_pt, FP);

        for (int s = 0; s < DEPTH; s++)
            wr(s, skey(s), spt(s), skey(s) ^ spt(s) ^ ((s == 2) ? 128'h1 : 128'h0));
        b = enb_cnt;
        go(4);
        wait_done(200, c);
        chk("four_cycles", c, 48);
        chk("four_pass", pass_cnt, 3);
        chk("four_fail", fail_cnt, 1);
        chk("four_ffi", first_fail_idx, 2);
        chk("four_ffv", first_fail_vld, 1);
        chk("four_issues", enb_cnt - b, 4);
        chk("four_gap01", enb_cyc[b+1] - enb_cyc[b], 12);
        chk("four_gap12", enb_cyc[b+2] - enb_cyc[b+1], 12);
        chk("four_gap23", enb_cyc[b+3] - enb_cyc[b+2], 12);
        chk("four_busy_after", busy, 0);

        b = enb_cnt;
        go(4);
        repeat (3) @(negedge clk);
        cfg_we = 1'b1; cfg_addr = '0; cfg_key = ~skey(0); cfg_pt = '0; cfg_exp = '1;
        start = 1'b1; num_vec = 5'd1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        wait_done(200, c);
        chk("dist_pass", pass_cnt, 3);
        chk("dist_fail", fail_cnt, 1);
        chk("dist_ffi", first_fail_idx, 2);
        chk("dist_issues", enb_cnt - b, 4);
        go(1);
        chk("dist_slot0_key", dut_key, skey(0));
        wait_done(100, c);
        chk("dist_slot0_pass", pass_cnt, 1);
        chk("dist_slot0_fail", fail_cnt, 0);

        b = enb_cnt;
        go(0);
        chk("zero_done_t1", done, 1);
        wait_done(10, c);
        chk("zero_cycles", c, 0);
        chk("zero_pass", pass_cnt, 0);
        chk("zero_fail", fail_cnt, 0);
        repeat (3) @(negedge clk);
        chk("zero_issues", enb_cnt - b, 0);
        chk("zero_busy", busy, 0);

        b = enb_cnt;
        go(20);
        wait_done(400, c);
        chk("clamp_cycles", c, 192);
        chk("clamp_issues", enb_cnt - b, 16);
        chk("clamp_pass", pass_cnt, 15);
        chk("clamp_fail", fail_cnt, 1);
        chk("clamp_ffi", first_fail_idx, 2);

        b = enb_cnt;
        go(4);
        k = 0;
        while (enb_cnt - b < 2 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mid_reached_v1", enb_cnt - b, 2);
        repeat (3) @(negedge clk);
        chk("mid_pre_pass", pass_cnt, 1);
        chk("mid_pre_key", dut_key, skey(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mid_busy", busy, 0);
        chk("mid_enb", dut_enb, 0);
        chk("mid_pass", pass_cnt, 0);
        chk("mid_key", dut_key, 0);
        chk("mid_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        b = enb_cnt;
        go(4);
        wait_done(200, c);
        chk("rerun_cycles", c, 48);
        chk("rerun_pass", pass_cnt, 3);
        chk("rerun_fail", fail_cnt, 1);
        chk("rerun_ffi", first_fail_idx, 2);
        chk("rerun_issues", enb_cnt - b, 4);

        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = '0; cfg_key = ~skey(0); cfg_pt = spt(0); cfg_exp = ~skey(0) ^ spt(0);
        start = 1'b1; num_vec = 5'd1;
        @(negedge clk);
        cfg_we = 1'b0; start = 1'b0;
        chk("simul_key", dut_key, ~skey(0));
        wait_done(100, c);
        chk("simul_pass", pass_cnt, 1);
        chk("simul_fail", fail_cnt, 0);
        chk("simul_tmo", timeout_err, 0);

`ifdef AES_CHK_TIMEOUT_EN
        core_silent = 1'b1;
        b = enb_cnt;
        go(2);
        wait_done(400, c);
        chk("tmo_cycles", c, 130);
        chk("tmo_fail", fail_cnt, 2);
        chk("tmo_pass", pass_cnt, 0);
        chk("tmo_err", timeout_err, 1);
        chk("tmo_ffi", first_fail_idx, 0);
        chk("tmo_ffv", first_fail_vld, 1);
        chk("tmo_issues", enb_cnt - b, 2);
        core_silent = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes_vector_checker.md
# aes_vector_checker

Synthesizable, parametrised stimulus/response engine for the AES core. It holds a programmable table of key/plaintext/expected-ciphertext vectors and, on `start`, issues each vector to the core through a one-cycle `dut_enb` pulse. It waits for the core's result, compares it, and accumulates pass/fail statistics. It replaces single-vector hand stimulus and sits beside `top` on silicon, FPGA or in simulation as a built-in self-test.

## Interface
- `N`, 128, data/key width in bits
- `DEPTH`, 16, number of vector slots
- `AW`, 4, address width; DEPTH ≤ 2^AW
- `TIMEOUT`, 64, max cycles to wait for `dut_valid` (used only with macro)

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `cfg_we` in 1 — write vector slot `cfg_addr`
- `cfg_addr` in AW — slot index
- `cfg_key`, `cfg_pt`, `cfg_exp` in N each — key, plaintext, expected ciphertext
- `num_vec` in AW+1 — vectors to run, sampled on `start`
- `start` in 1 — begin run (pulse)
- `dut_enb` out 1 — one-cycle issue strobe to core
- `dut_key`, `dut_pt` out N — registered stimulus, stable from issue until next issue
- `dut_ct` in N — core result
- `dut_valid` in 1 — `dut_ct` valid this cycle
- `busy` out 1; `done` out 1
- `pass_cnt`, `fail_cnt` out AW+1
- `first_fail_idx` out AW; `first_fail_vld` out 1
- `timeout_err` out 1

## Operation
- FSM states: IDLE, ISSUE, WAIT, CHECK, DONE.
- IDLE:
  - `cfg_we` writes all three arrays at `cfg_addr`; `cfg_addr` ≥ DEPTH is ignored.
  - On `start`: latch `n = min(num_vec, DEPTH)`, clear counters, `first_fail_vld`, `timeout_err` and `done`; set idx=0.
  - If n=0, go to DONE; otherwise go to ISSUE.
- ISSUE: load `dut_key`/`dut_pt` from slot idx, assert `dut_enb` for exactly this cycle, go to WAIT.
- WAIT: on `dut_valid`, capture `dut_ct` into a result register and go to CHECK. A `dut_valid` in the ISSUE cycle is ignored.
- CHECK:
  - result == exp[idx]: `pass_cnt`+1.
  - Otherwise: `fail_cnt`+1, and the first failure of the run records `first_fail_idx`=idx and sets `first_fail_vld`.
  - If idx==n-1, go to DONE; else idx+1 and go to ISSUE.
- DONE: `done`=1 and is held; all results are held. Go to IDLE on the same cycle, so `start` is accepted on the next cycle.
- `busy`=1 in ISSUE/WAIT/CHECK.
- `cfg_we` while busy is ignored; `start` while busy is ignored. Simultaneous `start` and `cfg_we` in IDLE: the write commits and the run uses the new data for that slot.
- Counters never wrap, since max value is DEPTH ≤ 2^AW < 2^(AW+1).

## Timing
- Reset values: all outputs 0, FSM=IDLE, stimulus registers 0. Vector memory is not reset.
- `start` at cycle t: `dut_enb` at t+1.
- Per vector: 1 (ISSUE) + W (WAIT, W ≥ 1 cycles until `dut_valid` inclusive) + 1 (CHECK).
- Counters update at the end of CHECK.
- `done` rises 1 cycle after the last CHECK; for n=0 it rises at t+1.
- Reset asserted mid-run: immediate return to IDLE, all outputs 0, no `dut_enb` glitch.

## Configuration
- `AES_CHK_TIMEOUT_EN` defined:
  - WAIT has a cycle counter, cleared in ISSUE.
  - If it reaches TIMEOUT without `dut_valid`, the vector counts as a fail (first-fail capture applies), `timeout_err` is set sticky until the next `start`, and the FSM proceeds as from CHECK.
- Undefined: WAIT blocks indefinitely, no counter logic, `timeout_err` tied 0.

## Test plan
- FIPS-197 vector in slot 0 (key 000102…0f, pt 00112233…ff, exp 69c4e0d86a7b0430d8cdb78070b4c55a), num_vec=1, model core with 10-cycle latency -> one `dut_enb` pulse, `done`, pass_cnt=1, fail_cnt=0, `first_fail_vld`=0.
- Four slots, slot 2 exp bit 0 flipped, num_vec=4 -> pass_cnt=3, fail_cnt=1, first_fail_idx=2, four `dut_enb` pulses each separated by 12 cycles.
- num_vec=0 -> `done` at t+1, no `dut_enb`, counters 0; num_vec=20 with DEPTH=16 -> exactly 16 issues.
- `cfg_we` to slot 0 during WAIT and second `start` while busy -> both ignored, results identical to the undisturbed run.
- `rst_n` low during WAIT of vector 1 -> outputs 0 asynchronously. After release, a `start` reruns from idx 0 correctly.
- With `AES_CHK_TIMEOUT_EN`, TIMEOUT=64, core never asserts valid, num_vec=2 -> `done` after 2×(1+64) cycles, fail_cnt=2, `timeout_err`=1, first_fail_idx=0.
